// File: rtl/rx_path_aligner.sv
// rx_path_aligner: collects I/Q samples from up to four skewed DDC paths into
// one coherent set, emits it with a single-cycle rxstrobe, flags sets that
// cannot be aligned and can substitute a ramp pattern for FIFO/USB checkout.
module rx_path_aligner #(
   parameter int MAX_SKEW = 15
) (
   input  logic        rxclk,
   input  logic        reset,
   input  logic [3:0]  channels,
   input  logic        test_mode,
   input  logic        clear_status,
   input  logic [3:0]  strobe_in,
   input  logic [15:0] i_0,
   input  logic [15:0] i_1,
   input  logic [15:0] i_2,
   input  logic [15:0] i_3,
   input  logic [15:0] q_0,
   input  logic [15:0] q_1,
   input  logic [15:0] q_2,
   input  logic [15:0] q_3,
   output logic [15:0] ch_0,
   output logic [15:0] ch_1,
   output logic [15:0] ch_2,
   output logic [15:0] ch_3,
   output logic [15:0] ch_4,
   output logic [15:0] ch_5,
   output logic [15:0] ch_6,
   output logic [15:0] ch_7,
   output logic        rxstrobe,
   output logic        skew_error
);

   localparam int TW = $clog2(MAX_SKEW + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   state_t         state_reg;
   logic [3:0]     chan_reg;
   logic [3:0]     en_mask;
   logic [3:0]     live;
   logic [3:0]     mask_reg;
   logic [TW-1:0]  timer_reg;
   logic [15:0]    ramp_reg;
   logic           rxstrobe_reg;
   logic           skew_error_reg;
   logic           chan_change;
   logic           emit_now;
   logic [15:0]    i_s [4];
   logic [15:0]    q_s [4];

   assign i_s[0] = i_0;
   assign i_s[1] = i_1;
   assign i_s[2] = i_2;
   assign i_s[3] = i_3;
   assign q_s[0] = q_0;
   assign q_s[1] = q_1;
   assign q_s[2] = q_2;
   assign q_s[3] = q_3;

   // Enabled paths follow the registered channel count; illegal counts disable all paths
   always_comb begin
      en_mask = 4'b0000;
      case (chan_reg)
         4'd2:    en_mask = 4'b0001;
         4'd4:    en_mask = 4'b0011;
         4'd6:    en_mask = 4'b0111;
         4'd8:    en_mask = 4'b1111;
         default: en_mask = 4'b0000;
      endcase
   end

   assign live        = strobe_in & en_mask;
   assign chan_change = (channels != chan_reg);
   assign emit_now    = (state_reg == EMIT);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_path
         logic [15:0] hold_i_reg;
         logic [15:0] hold_q_reg;
         logic [15:0] ch_i_reg;
         logic [15:0] ch_q_reg;

         // Holding registers take every enabled strobe; stale data is never emitted
         // because the capture mask must be refilled before completion.
         always_ff @(posedge rxclk) begin
            if (reset) begin
               hold_i_reg <= 16'h0000;
               hold_q_reg <= 16'h0000;
            end else if (live[gi]) begin
               hold_i_reg <= i_s[gi];
               hold_q_reg <= q_s[gi];
            end
         end

         // Output words load once per set on the EMIT edge; disabled paths read zero
         always_ff @(posedge rxclk) begin
            if (reset) begin
               ch_i_reg <= 16'h0000;
               ch_q_reg <= 16'h0000;
            end else if (emit_now) begin
               if (!en_mask[gi]) begin
                  ch_i_reg <= 16'h0000;
                  ch_q_reg <= 16'h0000;
               end else if (test_mode) begin
                  ch_i_reg <= ramp_reg;
                  ch_q_reg <= ~ramp_reg;
               end else begin
                  ch_i_reg <= hold_i_reg;
                  ch_q_reg <= hold_q_reg;
               end
            end
         end
      end
   endgenerate

   assign ch_0 = g_path[0].ch_i_reg;
   assign ch_1 = g_path[0].ch_q_reg;
   assign ch_2 = g_path[1].ch_i_reg;
   assign ch_3 = g_path[1].ch_q_reg;
   assign ch_4 = g_path[2].ch_i_reg;
   assign ch_5 = g_path[2].ch_q_reg;
   assign ch_6 = g_path[3].ch_i_reg;
   assign ch_7 = g_path[3].ch_q_reg;

   assign rxstrobe   = rxstrobe_reg;
   assign skew_error = skew_error_reg;

   // Alignment FSM: capture mask, skew timer, status flag, ramp and strobe
   always_ff @(posedge rxclk) begin
      if (reset) begin
         state_reg      <= IDLE;
         chan_reg       <= 4'd0;
         mask_reg       <= 4'b0000;
         timer_reg      <= '0;
         ramp_reg       <= 16'h0000;
         rxstrobe_reg   <= 1'b0;
         skew_error_reg <= 1'b0;
      end else begin
         chan_reg     <= channels;
         rxstrobe_reg <= emit_now;
         if (emit_now && test_mode) begin
            ramp_reg <= ramp_reg + 16'd1;
         end
         // Any set event further down overrides this clear
         if (clear_status) begin
            skew_error_reg <= 1'b0;
         end

         case (state_reg)
            IDLE, EMIT: begin
               // EMIT lasts one cycle and doubles as an IDLE edge for new strobes
               timer_reg <= '0;
               if (live != 4'b0000) begin
                  mask_reg  <= live;
                  state_reg <= (live == en_mask) ? EMIT : COLLECT;
               end else begin
                  mask_reg  <= 4'b0000;
                  state_reg <= IDLE;
               end
            end
            COLLECT: begin
               if (chan_change) begin
                  // Reconfiguration silently drops the partial set
                  mask_reg  <= 4'b0000;
                  timer_reg <= '0;
                  state_reg <= IDLE;
               end else if ((live & mask_reg) != 4'b0000) begin
                  // Repeat strobe: restart from this edge; a seed that already
                  // covers every path is complete and goes straight to EMIT
                  skew_error_reg <= 1'b1;
                  mask_reg       <= live;
                  timer_reg      <= '0;
                  state_reg      <= (live == en_mask) ? EMIT : COLLECT;
               end else if ((mask_reg | live) == en_mask) begin
                  mask_reg  <= en_mask;
                  timer_reg <= '0;
                  state_reg <= EMIT;
               end else if (timer_reg == TW'(MAX_SKEW - 1)) begin
                  skew_error_reg <= 1'b1;
                  mask_reg       <= 4'b0000;
                  timer_reg      <= '0;
                  state_reg      <= IDLE;
               end else begin
                  mask_reg  <= mask_reg | live;
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: begin
               mask_reg  <= 4'b0000;
               timer_reg <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_path_aligner.sv
// tb_rx_path_aligner: scoreboard bench; expected sets are queued when the
// completing strobe is driven and compared when rxstrobe appears.
module tb_rx_path_aligner;

   logic        rxclk = 1'b0;
   logic        reset;
   logic [3:0]  channels;
   logic        test_mode;
   logic        clear_status;
   logic [3:0]  strobe_in;
   logic [15:0] i_0, i_1, i_2, i_3, q_0, q_1, q_2, q_3;
   logic [15:0] ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
   logic        rxstrobe;
   logic        skew_error;

   typedef struct {
      logic [7:0][15:0] ch;
      int               cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          pulses = 0;
   logic [15:0] cap_i [4];
   logic [15:0] cap_q [4];
   logic [15:0] ramp_m = 16'h0000;

   rx_path_aligner #(.MAX_SKEW(15)) dut (
      .rxclk(rxclk), .reset(reset), .channels(channels), .test_mode(test_mode),
      .clear_status(clear_status), .strobe_in(strobe_in),
      .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
      .q_0(q_0), .q_1(q_1), .q_2(q_2), .q_3(q_3),
      .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
      .ch_4(ch_4), .ch_5(ch_5), .ch_6(ch_6), .ch_7(ch_7),
      .rxstrobe(rxstrobe), .skew_error(skew_error)
   );

   always #5 rxclk = ~rxclk;

   always @(posedge rxclk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every pulse must match the oldest queued set and its cycle
   always @(negedge rxclk) begin
      if (rxstrobe === 1'b1) begin
         exp_t e;
         logic [7:0][15:0] got;
         pulses++;
         got = {ch_7, ch_6, ch_5, ch_4, ch_3, ch_2, ch_1, ch_0};
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            for (int k = 0; k < 8; k++) begin
               check($sformatf("ch_%0d", k), {16'h0, got[k]}, {16'h0, e.ch[k]});
            end
            $display("set #%0d at cycle %0d: ch0=%h ch1=%h ch2=%h ch3=%h ch6=%h ch7=%h",
                     pulses, cyc, ch_0, ch_1, ch_2, ch_3, ch_6, ch_7);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge rxclk);
      #1;
   endtask

   // Drive one strobe edge; when 'last' the set completes on this edge and is queued
   task automatic drive(input logic [3:0] s, input logic [63:0] iv, input logic [63:0] qv,
                        input bit last, input logic [3:0] en);
      exp_t e;
      for (int p = 0; p < 4; p++) begin
         if (s[p] && en[p]) begin
            cap_i[p] = iv[p*16 +: 16];
            cap_q[p] = qv[p*16 +: 16];
         end
      end
      if (last) begin
         for (int p = 0; p < 4; p++) begin
            if (!en[p]) begin
               e.ch[2*p]   = 16'h0000;
               e.ch[2*p+1] = 16'h0000;
            end else if (test_mode) begin
               e.ch[2*p]   = ramp_m;
               e.ch[2*p+1] = ~ramp_m;
            end else begin
               e.ch[2*p]   = cap_i[p];
               e.ch[2*p+1] = cap_q[p];
            end
         end
         if (test_mode) ramp_m = ramp_m + 16'd1;
         e.cyc = cyc + 2;
         sb_q.push_back(e);
      end
      strobe_in = s;
      {i_3, i_2, i_1, i_0} = iv;
      {q_3, q_2, q_1, q_0} = qv;
      tick(1);
      strobe_in = 4'b0000;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      int p0;
      reset = 1'b1; channels = 4'd0; test_mode = 1'b0; clear_status = 1'b0;
      strobe_in = 4'b0000;
      {i_3, i_2, i_1, i_0} = '0;
      {q_3, q_2, q_1, q_0} = '0;
      tick(3);
      check("rst_ch", {ch_7, ch_6, ch_5, ch_4} | {ch_3, ch_2, ch_1, ch_0}, 32'h0);
      check("rst_rxstrobe", {31'd0, rxstrobe}, 32'd0);
      check("rst_skew", {31'd0, skew_error}, 32'd0);
      reset = 1'b0;

      // Single path
      channels = 4'd2; tick(3);
      drive(4'b0001, 64'h1234, 64'hABCD, 1'b1, 4'b0001);
      tick(4);

      // Four skewed paths at relative edges 0,2,3,5
      channels = 4'd8; tick(3);
      drive(4'b0001, rnd64(), rnd64(), 1'b0, 4'b1111);
      tick(1);
      drive(4'b0010, rnd64(), rnd64(), 1'b0, 4'b1111);
      drive(4'b0100, rnd64(), rnd64(), 1'b0, 4'b1111);
      tick(1);
      drive(4'b1000, rnd64(), rnd64(), 1'b1, 4'b1111);
      tick(4);
      check("skew_ok_8ch", {31'd0, skew_error}, 32'd0);

      // Missing path: timeout exactly 15 edges after first capture
      channels = 4'd4; tick(3);
      p0 = pulses;
      drive(4'b0001, rnd64(), rnd64(), 1'b0, 4'b0011);
      tick(14);
      check("timeout_edge14", {31'd0, skew_error}, 32'd0);
      tick(1);
      check("timeout_edge15", {31'd0, skew_error}, 32'd1);
      tick(5);
      check("timeout_no_pulse", pulses - p0, 32'd0);
      clear_status = 1'b1; tick(1); clear_status = 1'b0;
      check("clear_status", {31'd0, skew_error}, 32'd0);

      // Repeat strobe on path 0: set restarts with the second p0 sample
      tick(2);
      drive(4'b0001, 64'h1111, 64'h2222, 1'b0, 4'b0011);
      tick(1);
      drive(4'b0001, 64'h3333, 64'h4444, 1'b0, 4'b0011);
      drive(4'b0010, 64'h5555_0000, 64'h6666_0000, 1'b1, 4'b0011);
      tick(3);
      check("dup_skew_error", {31'd0, skew_error}, 32'd1);
      clear_status = 1'b1; tick(1); clear_status = 1'b0;

      // Ramp test pattern over three sets
      test_mode = 1'b1; tick(1);
      for (int k = 0; k < 3; k++) begin
         drive(4'b0011, rnd64(), rnd64(), 1'b1, 4'b0011);
         tick(3);
      end
      test_mode = 1'b0; tick(1);

      // Illegal channel counts ignore strobes
      p0 = pulses;
      for (int k = 0; k < 2; k++) begin
         channels = (k == 0) ? 4'd5 : 4'd0; tick(3);
         for (int r = 0; r < 6; r++) begin
            drive(4'($urandom_range(1, 15)), rnd64(), rnd64(), 1'b0, 4'b0000);
         end
         tick(20);
      end
      check("illegal_no_pulse", pulses - p0, 32'd0);
      check("illegal_no_skew", {31'd0, skew_error}, 32'd0);

      // Channel change mid-COLLECT drops the set without flagging
      channels = 4'd4; tick(3);
      p0 = pulses;
      drive(4'b0001, rnd64(), rnd64(), 1'b0, 4'b0011);
      channels = 4'd2;
      tick(20);
      check("chg_no_skew", {31'd0, skew_error}, 32'd0);
      check("chg_no_pulse", pulses - p0, 32'd0);
      drive(4'b0001, rnd64(), rnd64(), 1'b1, 4'b0001);
      tick(4);

      // Reset in the middle of a set
      channels = 4'd4; tick(3);
      p0 = pulses;
      drive(4'b0001, rnd64(), rnd64(), 1'b0, 4'b0011);
      reset = 1'b1; tick(1);
      check("midrst_ch", {ch_7, ch_6, ch_5, ch_4} | {ch_3, ch_2, ch_1, ch_0}, 32'h0);
      check("midrst_rxstrobe", {31'd0, rxstrobe}, 32'd0);
      reset = 1'b0;
      tick(20);
      check("midrst_no_pulse", pulses - p0, 32'd0);
      check("midrst_skew", {31'd0, skew_error}, 32'd0);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
